// File: rtl/alu_pkg.sv
// Shared opcode constants, flag bit positions and response-register state type
// for the ALU issue unit and its command FIFO.
package alu_pkg;

  localparam logic [3:0] SEL_ADD = 4'h0;
  localparam logic [3:0] SEL_SUB = 4'h1;
  localparam logic [3:0] SEL_MUL = 4'h2;
  localparam logic [3:0] SEL_DIV = 4'h3;
  localparam logic [3:0] SEL_AND = 4'h4;
  localparam logic [3:0] SEL_OR  = 4'h5;
  localparam logic [3:0] SEL_XOR = 4'h6;
  localparam logic [3:0] SEL_NOT = 4'h7;
  localparam logic [3:0] SEL_SHL = 4'h8;
  localparam logic [3:0] SEL_SHR = 4'h9;

  // First opcode that the external ALU does not implement.
  localparam logic [3:0] ILLEGAL_SEL_MIN = 4'hA;

  // Bit positions inside rsp_flags = {div_by_zero, overflow, zero, carry}.
  localparam int unsigned FLAG_CARRY = 0;
  localparam int unsigned FLAG_ZERO  = 1;
  localparam int unsigned FLAG_OVF   = 2;
  localparam int unsigned FLAG_DBZ   = 3;

  typedef enum logic [0:0] {
    RSP_EMPTY = 1'b0,
    RSP_FULL  = 1'b1
  } rsp_state_e;

  function automatic logic is_legal_sel(input logic [3:0] sel);
    return (sel < ILLEGAL_SEL_MIN);
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: stores {a, b, sel} entries in order; head is shown
// combinationally and reads as all-zero while empty.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_a_i,
  input  logic [WIDTH-1:0] push_b_i,
  input  logic [3:0]       push_sel_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_a_o,
  output logic [WIDTH-1:0] head_b_o,
  output logic [3:0]       head_sel_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_a_q   [DEPTH];
  logic [WIDTH-1:0] mem_b_q   [DEPTH];
  logic [3:0]       mem_sel_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  assign empty_o   = (count_q == {CNT_W{1'b0}});
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign do_push_s = push_i && !full_o;
  assign do_pop_s  = pop_i && !empty_o;

  assign head_a_o   = empty_o ? {WIDTH{1'b0}} : mem_a_q[rd_ptr_q];
  assign head_b_o   = empty_o ? {WIDTH{1'b0}} : mem_b_q[rd_ptr_q];
  assign head_sel_o = empty_o ? 4'h0 : mem_sel_q[rd_ptr_q];

  // Next pointer/count values; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_a_q[wr_ptr_q]   <= push_a_i;
      mem_b_q[wr_ptr_q]   <= push_b_i;
      mem_sel_q[wr_ptr_q] <= push_sel_i;
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// ALU issue unit: queues commands, drives the FIFO head to an external
// combinational ALU, captures its outputs into a single response register
// and counts (then drops) illegal opcodes.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [3:0]       cmd_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_quotient,
  input  logic [WIDTH-1:0] alu_remainder,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_div_by_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [WIDTH-1:0] rsp_aux,
  output logic [3:0]       rsp_sel,
  output logic [3:0]       rsp_flags,
  output logic [7:0]       err_cnt,
  output logic             busy
);

  logic       fifo_empty_s, fifo_full_s;
  logic       push_s, issue_s, legal_s, load_s;
  logic [WIDTH-1:0] new_result_s;

  rsp_state_e       state_q, state_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [WIDTH-1:0] rsp_aux_q, rsp_aux_d;
  logic [3:0]       rsp_sel_q, rsp_sel_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  assign cmd_ready = !fifo_full_s;
  assign push_s    = cmd_valid && cmd_ready;
  assign issue_s   = !fifo_empty_s && ((state_q == RSP_EMPTY) || rsp_ready);
  assign legal_s   = is_legal_sel(alu_sel);
  assign load_s    = issue_s && legal_s;

  alu_cmd_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push_s),
    .push_a_i   (cmd_a),
    .push_b_i   (cmd_b),
    .push_sel_i (cmd_sel),
    .pop_i      (issue_s),
    .head_a_o   (alu_a),
    .head_b_o   (alu_b),
    .head_sel_o (alu_sel),
    .empty_o    (fifo_empty_s),
    .full_o     (fifo_full_s)
  );

  // Response register state: filled by a legal issue, drained by rsp_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RSP_EMPTY: begin
        if (load_s) begin
          state_d = RSP_FULL;
        end else begin
          state_d = RSP_EMPTY;
        end
      end
      RSP_FULL: begin
        if (load_s) begin
          state_d = RSP_FULL;
        end else if (rsp_ready) begin
          state_d = RSP_EMPTY;
        end else begin
          state_d = RSP_FULL;
        end
      end
      default: state_d = RSP_EMPTY;
    endcase
  end

  // Response payload and illegal-opcode counter; payload holds unless a legal issue.
  always_comb begin
    new_result_s = (alu_sel == SEL_DIV) ? alu_quotient : alu_result;
    rsp_result_d = rsp_result_q;
    rsp_aux_d    = rsp_aux_q;
    rsp_sel_d    = rsp_sel_q;
    rsp_flags_d  = rsp_flags_q;
    err_cnt_d    = err_cnt_q;
    if (load_s) begin
      rsp_result_d           = new_result_s;
      rsp_aux_d              = (alu_sel == SEL_DIV) ? alu_remainder : {WIDTH{1'b0}};
      rsp_sel_d              = alu_sel;
      rsp_flags_d[FLAG_CARRY] = alu_carry;
      rsp_flags_d[FLAG_ZERO]  = (new_result_s == {WIDTH{1'b0}});
      rsp_flags_d[FLAG_OVF]   = alu_overflow;
      rsp_flags_d[FLAG_DBZ]   = alu_div_by_zero;
    end else begin
      rsp_result_d = rsp_result_q;
    end
    if (issue_s && !legal_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RSP_EMPTY;
      rsp_result_q <= {WIDTH{1'b0}};
      rsp_aux_q    <= {WIDTH{1'b0}};
      rsp_sel_q    <= 4'h0;
      rsp_flags_q  <= 4'h0;
      err_cnt_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      rsp_result_q <= rsp_result_d;
      rsp_aux_q    <= rsp_aux_d;
      rsp_sel_q    <= rsp_sel_d;
      rsp_flags_q  <= rsp_flags_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign rsp_valid  = (state_q == RSP_FULL);
  assign rsp_result = rsp_result_q;
  assign rsp_aux    = rsp_aux_q;
  assign rsp_sel    = rsp_sel_q;
  assign rsp_flags  = rsp_flags_q;
  assign err_cnt    = err_cnt_q;
  assign busy       = !fifo_empty_s || rsp_valid;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit with a behavioural external ALU.
module tb_alu_issue_unit;

  typedef struct packed {
    logic [7:0] res;
    logic [7:0] aux;
    logic [3:0] sel;
    logic [3:0] flags;
  } exp_t;

  logic       clk, rst_n;
  logic       cmd_valid, cmd_ready;
  logic [7:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_result, alu_quotient, alu_remainder;
  logic       alu_carry, alu_overflow, alu_div_by_zero;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_result, rsp_aux;
  logic [3:0] rsp_sel, rsp_flags;
  logic [7:0] err_cnt;
  logic       busy;

  logic [8:0]  alu_t9;
  logic [15:0] alu_p16;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pop_cnt = 0;
  logic rdy_rand = 1'b0;
  logic rdy_fixed = 1'b1;

  alu_issue_unit #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_quotient(alu_quotient), .alu_remainder(alu_remainder),
    .alu_carry(alu_carry), .alu_overflow(alu_overflow), .alu_div_by_zero(alu_div_by_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_aux(rsp_aux), .rsp_sel(rsp_sel), .rsp_flags(rsp_flags),
    .err_cnt(err_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External combinational ALU model.
  always_comb begin
    alu_t9 = 9'h000;
    alu_p16 = 16'h0000;
    alu_result = 8'h00;
    alu_carry = 1'b0;
    alu_overflow = 1'b0;
    alu_div_by_zero = 1'b0;
    alu_quotient = (alu_b == 8'h00) ? 8'h00 : alu_a / alu_b;
    alu_remainder = (alu_b == 8'h00) ? 8'h00 : alu_a % alu_b;
    case (alu_sel)
      4'h0: begin
        alu_t9 = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = alu_t9[7:0];
        alu_carry = alu_t9[8];
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_t9[7] != alu_a[7]);
      end
      4'h1: begin
        alu_t9 = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = alu_t9[7:0];
        alu_carry = alu_t9[8];
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_t9[7] != alu_a[7]);
      end
      4'h2: begin
        alu_p16 = alu_a * alu_b;
        alu_result = alu_p16[7:0];
        alu_carry = |alu_p16[15:8];
      end
      4'h3: begin
        alu_result = 8'hEE;
        alu_div_by_zero = (alu_b == 8'h00);
      end
      4'h4: alu_result = alu_a & alu_b;
      4'h5: alu_result = alu_a | alu_b;
      4'h6: alu_result = alu_a ^ alu_b;
      4'h7: alu_result = ~alu_a;
      4'h8: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
      4'h9: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
      default: alu_result = 8'hFF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Expected response computed from operand values with integer arithmetic.
  function automatic exp_t ref_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    exp_t e;
    int   s, sa, sb;
    e = '0;
    e.sel = sel;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (sel)
      4'h0: begin s = int'(a) + int'(b); e.res = s[7:0]; e.flags[0] = (s > 255);
                  e.flags[2] = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'h1: begin s = int'(a) - int'(b); e.res = s[7:0]; e.flags[0] = (s < 0);
                  e.flags[2] = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'h2: begin s = int'(a) * int'(b); e.res = s[7:0]; e.flags[0] = (s > 255); end
      4'h3: begin
        if (b == 8'h00) e.flags[3] = 1'b1;
        else begin e.res = a / b; e.aux = a % b; end
      end
      4'h4: e.res = a & b;
      4'h5: e.res = a | b;
      4'h6: e.res = a ^ b;
      4'h7: e.res = ~a;
      4'h8: begin e.res = a << 1; e.flags[0] = a[7]; end
      4'h9: begin e.res = a >> 1; e.flags[0] = a[0]; end
      default: e.res = 8'h00;
    endcase
    e.flags[1] = (e.res == 8'h00);
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                      input logic [7:0] er, input logic [7:0] ea, input logic [3:0] ef);
    int   waitc;
    exp_t e;
    waitc = 0;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_valid = 1'b1;
    while (!cmd_ready && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!cmd_ready) begin
      chk("send_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      if (sel < 4'hA) begin
        e.res = er; e.aux = ea; e.sel = sel; e.flags = ef;
        exp_q.push_back(e);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_drain_busy"}, 32'(busy), 32'd0);
    chk({name, "_drain_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  // rsp_ready driver, updated shortly after each rising edge.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #2;
      rsp_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
    end
  end

  // Monitor: compare presented response with scoreboard head, pop on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got result 0x%0h sel 0x%0h, expected no response at %0t",
                 rsp_result, rsp_sel, $time);
      end else begin
        e = exp_q[0];
        chk("rsp_result", 32'(rsp_result), 32'(e.res));
        chk("rsp_aux", 32'(rsp_aux), 32'(e.aux));
        chk("rsp_sel", 32'(rsp_sel), 32'(e.sel));
        chk("rsp_flags", 32'(rsp_flags), 32'(e.flags));
        if (rsp_ready) begin
          void'(exp_q.pop_front());
          pop_cnt++;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   n0, n_ill;
    logic [7:0] ra, rb;
    logic [3:0] rs;
    exp_t re;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00; cmd_sel = 4'h0;
    #3;
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_err_cnt", 32'(err_cnt), 32'd0);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset_alu_sel", 32'(alu_sel), 32'd0);
    chk("reset_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ADD and its latency.
    send(8'hF0, 8'h20, 4'h0, 8'h10, 8'h00, 4'b0001);
    chk("lat_edge_k", 32'(rsp_valid), 32'd0);
    chk("head_zero_after_issue", 32'(alu_sel), 32'd0);
    @(posedge clk); #1;
    chk("lat_edge_k1", 32'(rsp_valid), 32'd1);
    wait_drain("add");

    // Divide, normal and by zero.
    send(8'd17, 8'd5, 4'h3, 8'd3, 8'd2, 4'b0000);
    send(8'd9, 8'd0, 4'h3, 8'd0, 8'd0, 4'b1010);
    wait_drain("div");

    // Back-pressure: fill response register and FIFO.
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    send(8'h01, 8'h02, 4'h0, 8'h03, 8'h00, 4'b0000);
    send(8'h05, 8'h03, 4'h1, 8'h02, 8'h00, 4'b0000);
    send(8'hF0, 8'h0F, 4'h6, 8'hFF, 8'h00, 4'b0000);
    send(8'hF0, 8'h3C, 4'h4, 8'h30, 8'h00, 4'b0000);
    send(8'h81, 8'h00, 4'h8, 8'h02, 8'h00, 4'b0001);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("full_busy", 32'(busy), 32'd1);
    rdy_fixed = 1'b1;
    n0 = pop_cnt;
    repeat (5) @(posedge clk);
    #1;
    chk("burst_pops", 32'(pop_cnt - n0), 32'd5);
    chk("burst_done_valid", 32'(rsp_valid), 32'd0);

    // Illegal opcode between two SUBs, then saturation.
    send(8'h30, 8'h10, 4'h1, 8'h20, 8'h00, 4'b0000);
    send(8'h00, 8'h00, 4'hC, 8'h00, 8'h00, 4'b0000);
    send(8'h10, 8'h30, 4'h1, 8'hE0, 8'h00, 4'b0001);
    n0 = pop_cnt;
    wait_drain("illegal");
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) begin
      send(8'(i), 8'h00, 4'hA + 4'(i % 6), 8'h00, 8'h00, 4'h0);
    end
    wait_drain("sat");
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);

    // Reset with queued commands and a pending response.
    rdy_fixed = 1'b0;
    @(posedge clk); #1;
    send(8'h11, 8'h22, 4'h5, 8'h33, 8'h00, 4'b0000);
    send(8'h11, 8'h22, 4'h0, 8'h33, 8'h00, 4'b0000);
    send(8'h0F, 8'h0F, 4'h6, 8'h00, 8'h00, 4'b0010);
    send(8'h04, 8'h04, 4'h2, 8'h10, 8'h00, 4'b0000);
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rsp_result", 32'(rsp_result), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rdy_fixed = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
    chk("post_rst_not_busy", 32'(busy), 32'd0);

    // Random traffic with random back-pressure.
    rdy_rand = 1'b1;
    n_ill = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) rb = 8'h00;
      rs = 4'($urandom_range(0, 15));
      if (rs >= 4'hA) n_ill++;
      re = ref_rsp(ra, rb, rs);
      send(ra, rb, rs, re.res, re.aux, re.flags);
    end
    rdy_rand = 1'b0;
    rdy_fixed = 1'b1;
    wait_drain("random");
    chk("random_err_cnt", 32'(err_cnt), (n_ill > 255) ? 32'd255 : 32'(n_ill));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
